// File: rtl/seg7_pkg.sv
// Shared types and active-low segment glyphs for the 4-digit scanned display.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_idx_t;

    // Scan phase within one digit slot
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_display_decoder.sv
// Combinational BCD to active-low 7-segment glyph; codes 10..15 render as a dash.
module seg7_decoder
    import seg7_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg_n_c
);

    // Glyph lookup
    always_comb begin
        o_seg_n_c = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_n_c = SEG_0;
            4'd1:    o_seg_n_c = SEG_1;
            4'd2:    o_seg_n_c = SEG_2;
            4'd3:    o_seg_n_c = SEG_3;
            4'd4:    o_seg_n_c = SEG_4;
            4'd5:    o_seg_n_c = SEG_5;
            4'd6:    o_seg_n_c = SEG_6;
            4'd7:    o_seg_n_c = SEG_7;
            4'd8:    o_seg_n_c = SEG_8;
            4'd9:    o_seg_n_c = SEG_9;
            default: o_seg_n_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Assembles BCD digits into a shadow frame, commits whole frames to the active
// bank, and scans the active bank onto a 4-digit common-anode display.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [1:0] digit_sel,
    input  logic [3:0] digit_val,
    input  logic       frame_clr,
    input  logic [3:0] dp_mask,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_done
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

    bcd_t [3:0]  r_shadow;
    bcd_t [3:0]  r_active;
    logic [3:0]  r_mask;
    logic [PW-1:0] r_presc;
    digit_idx_t  r_idx;
    scan_state_t r_state;

    logic          w_wr;
    logic [3:0]    w_mask_set;
    logic          w_commit;
    bcd_t [3:0]    w_shadow_wr;
    logic          w_wrap;
    logic [PW-1:0] w_presc_nxt;
    scan_state_t   w_state_nxt;
    logic [3:0]    w_lz;
    logic          w_blank_digit;
    logic [6:0]    w_glyph;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    // A clear in the same cycle wins over the write, which is dropped
    assign w_wr       = digit_valid & ~frame_clr;
    assign w_mask_set = r_mask | (4'b0001 << digit_sel);
    assign w_commit   = w_wr && (w_mask_set == 4'hF);

    // Shadow contents including this cycle's write, so a commit captures it
    always_comb begin
        w_shadow_wr = r_shadow;
        if (w_wr) begin
            w_shadow_wr[digit_sel] = digit_val;
        end
    end

    // Shadow/active banks, written mask and commit pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_mask     <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            if (w_wr) begin
                r_shadow <= w_shadow_wr;
            end
            if (frame_clr) begin
                r_mask <= 4'h0;
            end else if (w_commit) begin
                r_mask   <= 4'h0;
                r_active <= w_shadow_wr;
            end else if (w_wr) begin
                r_mask <= w_mask_set;
            end
            frame_done <= w_commit;
        end
    end

    assign w_wrap      = (r_presc == PRESC_MAX);
    assign w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);

    // Slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_presc <= w_presc_nxt;
            if (w_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Leading-zero flags: digit i is blankable when it and every higher digit are zero
    always_comb begin
        w_lz[3] = (r_active[3] == 4'd0);
        w_lz[2] = w_lz[3] && (r_active[2] == 4'd0);
        w_lz[1] = w_lz[2] && (r_active[1] == 4'd0);
        w_lz[0] = 1'b0;
    end

    assign w_blank_digit = (LZ_BLANK != 0) && w_lz[r_idx];

    seg7_decoder u_decoder (
        .i_bcd     (r_active[r_idx]),
        .o_seg_n_c (w_glyph)
    );

    // Scan state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan next-state and pin values; anodes off during the anti-ghost window
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 4'hF;
        w_seg_nxt   = SEG_OFF;
        w_dp_nxt    = 1'b1;
        case (r_state)
            ST_BLANK: begin
                if (w_presc_nxt == BLANK_END) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_an_nxt  = ~(4'b0001 << r_idx);
                w_seg_nxt = w_blank_digit ? SEG_OFF : w_glyph;
                w_dp_nxt  = ~dp_mask[r_idx];
                if (w_wrap) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

    // Registered display pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_n  <= 4'hF;
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= w_an_nxt;
            seg_n <= w_seg_nxt;
            dp_n  <= w_dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Cycle-level scoreboard bench for seg7_scan_display (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_display;

    localparam int unsigned RDIV = 8;
    localparam int unsigned BLNK = 2;

    logic       clk;
    logic       rst_n;
    logic       digit_valid;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;
    logic       frame_clr;
    logic [3:0] dp_mask;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];

    int errors  = 0;
    int checks  = 0;
    int fd_seen = 0;

    int         m_presc;
    int         m_idx;
    int         m_active[4];
    int         m_shadow[4];
    logic [3:0] m_mask;

    seg7_scan_display #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLNK),
        .LZ_BLANK     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit_sel   (digit_sel),
        .digit_val   (digit_val),
        .frame_clr   (frame_clr),
        .dp_mask     (dp_mask),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference glyphs, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // One clock: drive inputs, predict the pins after the edge, compare
    task automatic tick(input logic rst, input logic v, input logic [1:0] sel,
                        input logic [3:0] val, input logic clr);
        exp_t       e;
        logic [3:0] ms;
        bit         blank;
        rst_n       = rst;
        digit_valid = v;
        digit_sel   = sel;
        digit_val   = val;
        frame_clr   = clr;
        ms = m_mask | (4'b0001 << sel);
        if (!rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
        end else begin
            e.fd = v && !clr && (ms == 4'hF);
            if (m_presc < int'(BLNK)) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.an  = ~(4'b0001 << m_idx);
                blank = (m_idx >= 1);
                for (int j = m_idx; j < 4; j++) begin
                    if (m_active[j] != 0) blank = 1'b0;
                end
                e.seg = blank ? 7'h7F : glyph(m_active[m_idx]);
                e.dp  = ~dp_mask[m_idx];
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            m_presc = 0;
            m_idx   = 0;
            m_mask  = 4'h0;
            for (int j = 0; j < 4; j++) begin
                m_active[j] = 0;
                m_shadow[j] = 0;
            end
        end else begin
            if (clr) begin
                m_mask = 4'h0;
            end else if (v) begin
                m_shadow[sel] = int'(val);
                if (ms == 4'hF) begin
                    for (int j = 0; j < 4; j++) m_active[j] = m_shadow[j];
                    m_mask = 4'h0;
                end else begin
                    m_mask = ms;
                end
            end
            if (m_presc == int'(RDIV) - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 4;
            end else begin
                m_presc = m_presc + 1;
            end
        end
        #1;
        if (frame_done === 1'b1) fd_seen++;
        e = sb_q.pop_front();
        checks++;
        assert (an_n === e.an) else begin
            errors++;
            $error("FAIL an_n: got %h expected %h (t=%0t)", an_n, e.an, $time);
        end
        checks++;
        assert (seg_n === e.seg) else begin
            errors++;
            $error("FAIL seg_n: got %h expected %h (t=%0t)", seg_n, e.seg, $time);
        end
        checks++;
        assert (dp_n === e.dp) else begin
            errors++;
            $error("FAIL dp_n: got %b expected %b (t=%0t)", dp_n, e.dp, $time);
        end
        checks++;
        assert (frame_done === e.fd) else begin
            errors++;
            $error("FAIL frame_done: got %b expected %b (t=%0t)", frame_done, e.fd, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] val);
        tick(1'b1, 1'b1, sel, val, 1'b0);
    endtask

    task automatic check_fd(input string tag, input int want);
        checks++;
        assert (fd_seen == want) else begin
            errors++;
            $error("FAIL %s: frame_done pulses %0d expected %0d", tag, fd_seen, want);
        end
        fd_seen = 0;
    endtask

    initial begin
        rst_n = 1'b0; digit_valid = 1'b0; digit_sel = 2'd0;
        digit_val = 4'd0; frame_clr = 1'b0; dp_mask = 4'b0000;
        m_presc = 0; m_idx = 0; m_mask = 4'h0;
        for (int j = 0; j < 4; j++) begin
            m_active[j] = 0;
            m_shadow[j] = 0;
        end

        // Reset held for 3 cycles, then a full scan of an all-zero frame
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(34);
        check_fd("reset_idle", 0);

        // Complete frame 1,2,3,4
        wr(2'd0, 4'd4); wr(2'd1, 4'd3); wr(2'd2, 4'd2); wr(2'd3, 4'd1);
        idle(36);
        check_fd("frame_write", 1);

        // Partial frame discarded by frame_clr, which drops the concurrent write
        wr(2'd0, 4'd8); wr(2'd1, 4'd8); wr(2'd2, 4'd8);
        tick(1'b1, 1'b1, 2'd3, 4'd8, 1'b1);
        idle(34);
        check_fd("frame_clr", 0);

        // Next full frame commits normally
        wr(2'd0, 4'd9); wr(2'd1, 4'd8); wr(2'd2, 4'd7); wr(2'd3, 4'd6);
        idle(34);
        check_fd("after_clr", 1);

        // Overwrite digit 0 and leading-zero blanking
        wr(2'd0, 4'd7); wr(2'd0, 4'd5); wr(2'd1, 4'd0); wr(2'd2, 4'd0); wr(2'd3, 4'd0);
        idle(34);
        check_fd("overwrite_lz", 1);

        // Invalid digit shows a dash, dp on digit 2, zero digit 1 not blanked
        dp_mask = 4'b0100;
        wr(2'd3, 4'd9); wr(2'd2, 4'd12); wr(2'd1, 4'd0); wr(2'd0, 4'd0);
        idle(36);
        check_fd("invalid_dp", 1);

        // Reset in the middle of slot 2
        for (int k = 0; k < 40 && !(m_presc == 5 && m_idx == 2); k++) idle(1);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(34);
        check_fd("mid_reset", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
